// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b pipeline types
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic {
        HZ_RUN    = 1'b0,
        HZ_FROZEN = 1'b1
    } lc3b_hz_state;

endpackage

// File: rtl/hz_sat_counter.sv
// rtl/hz_sat_counter.sv - saturating up-counter with synchronous clear
module hz_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Holds at all-ones rather than wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use bubble, memory freeze and branch flush control
module hazard_stall_unit
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    input  lc3b_reg          id_src1,
    input  lc3b_reg          id_src2,
    input  logic             ex_load_inst,
    input  logic             ex_regfile_write,
    input  lc3b_reg          ex_dest,
    input  logic             if_req,
    input  logic             if_resp,
    input  logic             mem_req,
    input  logic             mem_resp,
    input  logic             mem_branch_taken,
    output logic             pc_load,
    output logic             pc_sel_target,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             id_ex_bubble,
    output logic             flush_young,
    output logic [CNT_W-1:0] stall_cycles
);

    lc3b_hz_state state_q, state_d;
    logic         flush_pend_q, flush_pend_d;
    logic         if_pend, d_pend, freeze, lu, flush;
    logic         cnt_inc;

    assign if_pend = if_req & ~if_resp;
    assign d_pend  = mem_req & ~mem_resp;
    assign freeze  = if_pend | d_pend;
    assign lu      = ex_load_inst & ex_regfile_write &
                     ((id_uses_sr1 & (id_src1 == ex_dest)) |
                      (id_uses_sr2 & (id_src2 == ex_dest)));
    assign flush   = mem_branch_taken | flush_pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HZ_RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // A branch resolved while frozen is remembered until the pipe can move.
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            HZ_RUN:    if (freeze) state_d = HZ_FROZEN;
            HZ_FROZEN: if (!freeze) state_d = HZ_RUN;
            default:   state_d = HZ_RUN;
        endcase
        if (freeze) begin
            flush_pend_d = flush_pend_q | mem_branch_taken;
        end else if (flush) begin
            flush_pend_d = 1'b0;
        end
    end

    always_comb begin
        pc_load       = 1'b1;
        pc_sel_target = 1'b0;
        if_id_load    = 1'b1;
        id_ex_load    = 1'b1;
        ex_mem_load   = 1'b1;
        mem_wb_load   = 1'b1;
        id_ex_bubble  = 1'b0;
        flush_young   = 1'b0;
        cnt_inc       = 1'b0;
        if (reset || freeze) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
            flush_young = reset;
            cnt_inc     = ~reset;
        end else if (flush) begin
            pc_sel_target = 1'b1;
            flush_young   = 1'b1;
        end else if (lu) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_bubble = 1'b1;
            cnt_inc      = 1'b1;
        end
    end

    hz_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (reset),
        .inc  (cnt_inc),
        .count(stall_cycles)
    );

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline-control block paired with the forwarding unit in the 5-stage LC-3b pipeline.
- It resolves the hazards forwarding cannot cover:
  - load-use: a load in EX whose dest feeds the instruction in ID, so one bubble is inserted;
  - outstanding I-side/D-side memory transactions, which freeze the whole pipe;
  - taken control transfers resolved in MEM, which flush the younger stages.
- Drives every pipeline-register load enable, the PC load/select, and bubble/flush controls. Keeps a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- id_uses_sr1  in  1  ID instruction reads SR1
- id_uses_sr2  in  1  ID instruction reads SR2
- id_src1  in  lc3b_reg  ID SR1 index
- id_src2  in  lc3b_reg  ID SR2 index
- ex_load_inst  in  1  EX instruction is LDR/LDB/LDI
- ex_regfile_write  in  1  EX instruction writes the regfile
- ex_dest  in  lc3b_reg  EX destination register
- if_req  in  1  fetch request outstanding
- if_resp  in  1  fetch complete this cycle
- mem_req  in  1  MEM-stage data access outstanding
- mem_resp  in  1  data access complete this cycle
- mem_branch_taken  in  1  MEM instruction redirects the PC
- pc_load  out  1  PC register load enable
- pc_sel_target  out  1  1 = PC takes the MEM-stage target
- if_id_load  out  1  IF/ID load enable
- id_ex_load  out  1  ID/EX load enable
- ex_mem_load  out  1  EX/MEM load enable
- mem_wb_load  out  1  MEM/WB load enable
- id_ex_bubble  out  1  ID/EX loads a NOP this edge
- flush_young  out  1  IF/ID, ID/EX and EX/MEM load NOPs this edge
- stall_cycles  out  CNT_W  saturating count of freeze + bubble cycles

Behaviour:
- Signals (combinational):
  - if_pend = if_req & !if_resp
  - d_pend = mem_req & !mem_resp
  - freeze = if_pend | d_pend
- Load-use term, lu =
  - ex_load_inst & ex_regfile_write &
  - ((id_uses_sr1 & id_src1==ex_dest) | (id_uses_sr2 & id_src2==ex_dest))
- Registered state: state in {RUN, FROZEN}, flush_pend (1 bit), stall_cycles.
- Outputs are combinational from the inputs plus registered state (Mealy); there is zero-cycle latency from a hazard to the stall.
- Priority: reset > freeze > flush > load-use > normal.
- Reset cycle (reset high):
  - all *_load outputs = 0, pc_sel_target = 0, id_ex_bubble = 0, flush_young = 1;
  - next state RUN, flush_pend = 0, stall_cycles = 0.
- Freeze:
  - All loads = 0, flush_young = 0, id_ex_bubble = 0.
  - Next state FROZEN; stall_cycles increments.
  - If mem_branch_taken, set flush_pend.
- Flush: when not frozen and (mem_branch_taken | flush_pend):
  - all loads = 1, pc_sel_target = 1, flush_young = 1, id_ex_bubble = 0 (lu ignored);
  - clear flush_pend; next state RUN.
- Load-use: when not frozen, no flush, and lu:
  - pc_load = 0, if_id_load = 0;
  - id_ex_load = 1, id_ex_bubble = 1;
  - ex_mem_load = 1, mem_wb_load = 1;
  - stall_cycles increments.
  - On the next cycle the load is in MEM, so lu drops naturally and no second bubble occurs.
- Normal: all loads = 1, other controls 0.
- FROZEN to RUN on the first cycle in which freeze = 0. That cycle's outputs follow flush/load-use/normal rules.
- stall_cycles saturates at all-ones and never wraps.
- Simultaneous if_resp and mem_resp with no new requests: the freeze ends that cycle.
- flush_young never asserts in the same cycle as id_ex_bubble.
- Reset during FROZEN or with flush_pend set discards both.

Decomposition:
- lc3b_types: lc3b_reg (3-bit) already exists. Add enum lc3b_hz_state {HZ_RUN, HZ_FROZEN}.
- Sub-module: hz_sat_counter (parameterised CNT_W; inc, clr, saturating), instantiated once for stall_cycles.

Test Plan:
- LDR R2 in EX (ex_dest=2, load, write); ADD in ID with id_src1=2, uses_sr1 -> one cycle of pc_load=0, if_id_load=0, id_ex_bubble=1; next cycle lu=0, all loads 1; stall_cycles=1.
- Same stimulus with id_uses_sr1=0 and id_src2=2, uses_sr2=0 -> no bubble; stall_cycles stays 0.
- mem_req=1, mem_resp=0 for 4 cycles, then mem_resp=1 -> 4 cycles of all loads 0; on the resp cycle all loads 1; stall_cycles=4.
- mem_branch_taken=1 in cycle 2 of a 3-cycle freeze -> no flush while frozen; on the first unfrozen cycle flush_young=1, pc_sel_target=1, pc_load=1; flush_pend clears.
- mem_branch_taken=1 while lu=1 -> flush_young=1, id_ex_bubble=0, if_id_load=1.
- Preload counter near all-ones via a long freeze (CNT_W=4, 20 cycles) -> stall_cycles=15 holds; reset mid-freeze -> counter 0, state RUN, flush_young=1 that cycle.
